// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter. Each cycle it picks the next PC from the
//   incrementer, a branch or jump target, or the exception vector. It holds
//   the PC on stall or halt, and raises a one-cycle flush after every redirect.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, overrides everything
//   stall      hazard stall, hold pc
//   br_taken   branch resolved taken, load br_target
//   br_target  branch target address
//   jmp        unconditional jump, load jmp_target (wins over br_taken)
//   jmp_target jump target address
//   halt       halt instruction decoded, enter HALT
//   resume     leave HALT and advance past the halt instruction
//   exc        exception raised, save pc to epc and load EXC_VECTOR
//   pc         current PC (registered)
//   pc_plus    pc + INC modulo 2^WIDTH (combinational)
//   epc        PC saved at the last exception (registered)
//   flush      high for the cycle after a redirect
//   halted     high while halted
module pc_sequencer #(
  parameter int               WIDTH      = 16,
  parameter int               INC        = 2,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 16'h0002
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             halt,
  input  logic             resume,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             flush,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] epcNext;

  // Instructions are halfword aligned; any target loaded into pc drops bit 0.
  function automatic logic [WIDTH-1:0] alignPc(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:1], 1'b0};
  endfunction

  // Carry out is discarded so the counter wraps.
  assign pc_plus = pc + INC_W;

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    epcNext   = epc;
    unique case (state)
      RUN: begin
        if (exc) begin
          epcNext   = pc;
          pcNext    = alignPc(EXC_VECTOR);
          stateNext = FLUSH;
        end else if (halt) begin
          stateNext = HALT;
        end else if (jmp) begin
          pcNext    = alignPc(jmp_target);
          stateNext = FLUSH;
        end else if (br_taken) begin
          pcNext    = alignPc(br_target);
          stateNext = FLUSH;
        end else if (!stall) begin
          pcNext = pc_plus;
        end
      end
      FLUSH: begin
        // Control inputs here belong to the squashed instruction.
        if (!stall) begin
          pcNext = pc_plus;
        end
        stateNext = RUN;
      end
      HALT: begin
        // Resume skips past the halt instruction rather than re-fetching it.
        if (resume) begin
          pcNext    = pc_plus;
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      epc   <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      epc   <= epcNext;
    end
  end

  // Decoded from the state register only, so no input reaches these outputs.
  assign flush  = (state == FLUSH);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue. A monitor pops the queue on the
// falling edge and compares the outputs against those values.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        halt;
  logic        resume;
  logic        exc;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic [15:0] epc;
  logic        flush;
  logic        halted;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .halt      (halt),
    .resume    (resume),
    .exc       (exc),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .epc       (epc),
    .flush     (flush),
    .halted    (halted)
  );

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic [15:0] pcPlus;
    logic [15:0] epc;
    logic        flush;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are stable mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || pc_plus !== e.pcPlus || epc !== e.epc ||
          flush !== e.flush || halted !== e.halted) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus=%h epc=%h flush=%b halted=%b, expected pc=%h pc_plus=%h epc=%h flush=%b halted=%b",
                 e.nm, pc, pc_plus, epc, flush, halted,
                 e.pc, e.pcPlus, e.epc, e.flush, e.halted);
      end
    end
  end

  // Drive one cycle of inputs, clock it in, and queue the expected result.
  task automatic cyc(input string nm, input logic r, input logic st,
                     input logic br, input logic [15:0] bt,
                     input logic j, input logic [15:0] jt,
                     input logic h, input logic rs, input logic ex,
                     input logic [15:0] xPc, input logic [15:0] xPlus,
                     input logic [15:0] xEpc, input logic xFl, input logic xH);
    exp_t e;
    rst = r; stall = st; br_taken = br; br_target = bt;
    jmp = j; jmp_target = jt; halt = h; resume = rs; exc = ex;
    @(posedge clk);
    #1;
    e.nm = nm; e.pc = xPc; e.pcPlus = xPlus; e.epc = xEpc;
    e.flush = xFl; e.halted = xH;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    jmp = 1'b0; jmp_target = '0; halt = 1'b0; resume = 1'b0; exc = 1'b0;

    //   name          rst st br bt        j  jt        h  rs ex  pc        pc_plus   epc       fl hl
    cyc("reset",       1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    cyc("inc1",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0002, 16'h0004, 16'h0000, 0, 0);
    cyc("inc2",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0004, 16'h0006, 16'h0000, 0, 0);
    cyc("inc3",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0006, 16'h0008, 16'h0000, 0, 0);
    cyc("inc4",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0008, 16'h000A, 16'h0000, 0, 0);
    cyc("jmp300",      0, 0, 0, 16'h0000, 1, 16'd300,  0, 0, 0, 16'd300,  16'd302,  16'h0000, 1, 0);
    cyc("after300a",   0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'd302,  16'd304,  16'h0000, 0, 0);
    cyc("after300b",   0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'd304,  16'd306,  16'h0000, 0, 0);
    cyc("jmpFFFE",     0, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 0, 16'hFFFE, 16'h0000, 16'h0000, 1, 0);
    cyc("wrap",        0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    cyc("jmpOverBr",   0, 0, 1, 16'h0200, 1, 16'h0100, 0, 0, 0, 16'h0100, 16'h0102, 16'h0000, 1, 0);
    cyc("brInFlush",   0, 0, 1, 16'h0300, 0, 16'h0000, 0, 0, 0, 16'h0102, 16'h0104, 16'h0000, 0, 0);
    cyc("postFlush",   0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0104, 16'h0106, 16'h0000, 0, 0);
    cyc("jmp0010",     0, 0, 0, 16'h0000, 1, 16'h0010, 0, 0, 0, 16'h0010, 16'h0012, 16'h0000, 1, 0);
    cyc("stall1",      0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0012, 16'h0000, 0, 0);
    cyc("stall2",      0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0012, 16'h0000, 0, 0);
    cyc("stall3",      0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0012, 16'h0000, 0, 0);
    cyc("brOdd",       0, 0, 1, 16'h0041, 0, 16'h0000, 0, 0, 0, 16'h0040, 16'h0042, 16'h0000, 1, 0);
    cyc("afterBr",     0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0042, 16'h0044, 16'h0000, 0, 0);
    cyc("jmp001E",     0, 0, 0, 16'h0000, 1, 16'h001E, 0, 0, 0, 16'h001E, 16'h0020, 16'h0000, 1, 0);
    cyc("to0020",      0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0020, 16'h0022, 16'h0000, 0, 0);
    cyc("halt",        0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0020, 16'h0022, 16'h0000, 0, 1);
    cyc("haltExc",     0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0020, 16'h0022, 16'h0000, 0, 1);
    cyc("haltJmp",     0, 0, 1, 16'h0600, 1, 16'h0500, 0, 0, 0, 16'h0020, 16'h0022, 16'h0000, 0, 1);
    cyc("haltStall",   0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0020, 16'h0022, 16'h0000, 0, 1);
    cyc("resume",      0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0022, 16'h0024, 16'h0000, 0, 0);
    cyc("afterResume", 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0024, 16'h0026, 16'h0000, 0, 0);
    cyc("jmp002E",     0, 0, 0, 16'h0000, 1, 16'h002E, 0, 0, 0, 16'h002E, 16'h0030, 16'h0000, 1, 0);
    cyc("to0030",      0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0030, 16'h0032, 16'h0000, 0, 0);
    cyc("excOverHalt", 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h0002, 16'h0004, 16'h0030, 1, 0);
    cyc("rstInFlush",  1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    cyc("jmp0040",     0, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 16'h0040, 16'h0042, 16'h0000, 1, 0);
    cyc("excInFlush",  0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h0042, 16'h0044, 16'h0000, 0, 0);
    cyc("halt2",       0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0042, 16'h0044, 16'h0000, 0, 1);
    cyc("rstInHalt",   1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0002, 16'h0000, 0, 0);
    cyc("idleEnd",     0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0002, 16'h0004, 16'h0000, 0, 0);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d entries left in the queue, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 16-bit program counter and sequences the existing PC incrementer each cycle.
- Selects the next PC from increment, branch, jump or exception vector, and holds the PC on stall or halt.
- Emits a one-cycle fetch/decode flush after every redirect.
- Sits between the hazard/control unit and instruction memory in the processor datapath.

Parameters:
- WIDTH, 16, PC width in bits.
- INC, 2, byte increment per sequential instruction.
- RESET_PC, 16'h0000, PC value loaded on reset.
- EXC_VECTOR, 16'h0002, PC loaded when an exception is taken.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall; hold the PC.
- br_taken  input  1  branch resolved taken this cycle.
- br_target  input  WIDTH  branch target address.
- jmp  input  1  unconditional jump this cycle.
- jmp_target  input  WIDTH  jump target address.
- halt  input  1  halt instruction decoded.
- resume  input  1  leave the HALT state.
- exc  input  1  exception (overflow or illegal opcode) raised.
- pc  output  WIDTH  current PC (registered).
- pc_plus  output  WIDTH  combinational pc + INC, modulo 2^WIDTH.
- epc  output  WIDTH  PC saved at the last exception (registered).
- flush  output  1  registered; high while state is FLUSH.
- halted  output  1  registered; high while state is HALT.

Behaviour:
- Reset (rst=1 at an edge)
  - pc=RESET_PC, epc=0, state=RUN, flush=0, halted=0.
  - Reset has priority over every other input in every state, including mid-FLUSH and mid-HALT.
- States: RUN, FLUSH, HALT. Encoding is free. flush=(state==FLUSH), halted=(state==HALT).
- RUN: one action per edge, in this priority order:
  1. exc: epc<=pc, pc<=EXC_VECTOR, go to FLUSH.
  2. halt: pc held, go to HALT.
  3. jmp: pc<=jmp_target, go to FLUSH. jmp wins over a simultaneous br_taken.
  4. br_taken: pc<=br_target, go to FLUSH.
  5. stall: pc held, stay in RUN.
  6. Otherwise: pc<=pc_plus, stay in RUN.
- FLUSH:
  - Lasts exactly one cycle, then returns to RUN unconditionally.
  - The squashed instruction's br_taken, jmp, halt and exc are ignored.
  - stall=1 holds pc; otherwise pc<=pc_plus.
- HALT:
  - pc held, epc held.
  - exc, jmp, br_taken and stall are ignored.
  - resume=1: go to RUN and load pc<=pc_plus on the same edge (the halt instruction is not re-fetched).
- Arithmetic:
  - pc_plus = pc + INC, truncated to WIDTH bits (16'hFFFE + 2 = 16'h0000).
  - No carry out is produced.
- Alignment: bit 0 of br_target, jmp_target and EXC_VECTOR is forced to 0 when loaded into pc.
- Latency:
  - A redirect input sampled at edge N gives the new pc after edge N.
  - flush is high for the cycle after edge N.
  - No combinational path exists from inputs to pc, epc, flush or halted.

Test Plan:
- Reset then 4 free-running cycles -> pc = 0, 2, 4, 6, 8; flush=0; halted=0. Force pc=300 via jmp -> next increments give 302 then 304.
- Wrap-around: jmp_target=16'hFFFE, then one idle cycle -> pc=FFFE, then 0000; pc_plus=0002.
- jmp=1 (target 0x0100) and br_taken=1 (target 0x0200) in the same cycle -> pc=0x0100, flush high for exactly one cycle. A br_taken during that flush cycle is ignored and pc goes to 0x0102.
- stall for 3 cycles at pc=0x0010 -> pc holds 0x0010 throughout. br_target=0x0041 with br_taken -> pc=0x0040.
- halt at pc=0x0020, then exc and jmp pulses, then resume -> pc holds 0x0020 with halted=1 and epc unchanged. After resume, halted=0 and pc=0x0022.
- exc at pc=0x0030 simultaneous with halt -> epc=0x0030, pc=EXC_VECTOR, state FLUSH (not HALT). Assert rst during that flush cycle -> pc=0, epc=0, flush=0 on the next edge.
